// File: rtl/lsu_mem_port_if.sv
// Pipeline request/response and data-memory bus of the load/store port.
// master = pipeline plus memory side, slave = the port itself.
interface lsu_mem_port_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              stall;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              misalign;
    logic              timeout;
    logic              mem_en;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_rdata, mem_ack,
        input  stall, rsp_valid, rsp_rdata, misalign, timeout,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_rdata, mem_ack,
        output stall, rsp_valid, rsp_rdata, misalign, timeout,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store port: sized, byte-enabled, variable-latency data memory access with
// sign/zero extension, optional ack timeout and pipeline stall while outstanding.

module lsu_lane #(
    parameter int LANE      = 0,
    parameter int NUM_LANES = 4
) (
    input  logic [1:0]             size,
    input  logic [NUM_LANES*8-1:0] wdata,
    output logic [7:0]             lane_byte
);
    // Narrow stores repeat their low bytes so every lane carries the store data.
    always_comb begin
        unique case (size)
            2'b00:   lane_byte = wdata[7:0];
            2'b01:   lane_byte = wdata[(LANE % 2)*8 +: 8];
            2'b10:   lane_byte = wdata[(LANE % 4)*8 +: 8];
            default: lane_byte = wdata[LANE*8 +: 8];
        endcase
    end
endmodule

module lsu_mem_port #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_port_if.slave lsu
);
    localparam int NUM_LANES = XLEN / 8;
    localparam int LANE_W    = $clog2(NUM_LANES);
    localparam int CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic [1:0]        size;
        logic              uns;
        logic [LANE_W-1:0] lane;
    } acc_t;

    state_t                    state, state_nxt;
    acc_t                      acc;
    logic [CNT_W-1:0]          cnt;
    logic [LANE_W-1:0]         lane;
    logic                      mis, issue, go_mis, done_ack, done_to;
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] wdata_rep;
    logic [XLEN-1:0]           rd_sh, rd_mask, ld_fmt;
    logic                      rd_sgn;

    assign lane = lsu.req_addr[LANE_W-1:0];

    always_comb begin
        unique case (lsu.req_size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lsu.req_addr[0];
            SZ_W:    mis = |lsu.req_addr[1:0];
            default: mis = (XLEN == 32) || (|lsu.req_addr[2:0]);
        endcase
    end

    always_comb begin
        unique case (lsu.req_size)
            SZ_B:    be = NUM_LANES'(1) << lane;
            SZ_H:    be = NUM_LANES'(3) << lane;
            SZ_W:    be = NUM_LANES'(15) << lane;
            default: be = '1;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_lane #(.LANE(i), .NUM_LANES(NUM_LANES)) u_lane (
            .size      (lsu.req_size),
            .wdata     (lsu.req_wdata),
            .lane_byte (wdata_rep[i])
        );
    end

    // Extension is an OR with the inverted size mask, so full-width loads ignore uns.
    always_comb begin
        rd_sh   = lsu.mem_rdata >> {acc.lane, 3'b000};
        rd_mask = '1;
        rd_sgn  = rd_sh[XLEN-1];
        unique case (acc.size)
            SZ_B:    begin rd_mask = XLEN'(8'hFF);         rd_sgn = rd_sh[7];  end
            SZ_H:    begin rd_mask = XLEN'(16'hFFFF);      rd_sgn = rd_sh[15]; end
            SZ_W:    begin rd_mask = XLEN'(32'hFFFF_FFFF); rd_sgn = rd_sh[31]; end
            default: begin rd_mask = '1;                   rd_sgn = rd_sh[XLEN-1]; end
        endcase
        ld_fmt = (rd_sh & rd_mask) | ((rd_sgn && !acc.uns) ? ~rd_mask : '0);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        go_mis    = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        unique case (state)
            IDLE: if (lsu.req_valid) begin
                if (mis) begin go_mis = 1'b1; state_nxt = RESP; end
                else     begin issue  = 1'b1; state_nxt = BUSY; end
            end
            BUSY: if (lsu.mem_ack) begin
                done_ack  = 1'b1;
                state_nxt = RESP;
            end else if (TIMEOUT_CYC > 0 && cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                done_to   = 1'b1;
                state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu.stall     = rst && ((state == IDLE && lsu.req_valid) || state == BUSY);
    assign lsu.rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc           <= '0;
            cnt           <= '0;
            lsu.mem_en    <= 1'b0;
            lsu.mem_we    <= 1'b0;
            lsu.mem_be    <= '0;
            lsu.mem_addr  <= '0;
            lsu.mem_wdata <= '0;
            lsu.rsp_rdata <= '0;
            lsu.misalign  <= 1'b0;
            lsu.timeout   <= 1'b0;
        end else begin
            lsu.misalign <= go_mis;
            lsu.timeout  <= done_to;
            if (issue) begin
                acc           <= '{size: lsu.req_size, uns: lsu.req_unsigned, lane: lane};
                cnt           <= '0;
                lsu.mem_en    <= 1'b1;
                lsu.mem_we    <= lsu.req_we;
                lsu.mem_be    <= be;
                lsu.mem_addr  <= lsu.req_addr & ~ADDR_W'(NUM_LANES - 1);
                lsu.mem_wdata <= wdata_rep;
            end else if (state == BUSY && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (done_ack || done_to) begin
                lsu.mem_en <= 1'b0;
                lsu.mem_we <= 1'b0;
            end
            if (go_mis || done_to) lsu.rsp_rdata <= '0;
            else if (done_ack)     lsu.rsp_rdata <= lsu.mem_we ? '0 : ld_fmt;
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench: 32-bit port with an 8-cycle timeout and a 64-bit port with default timeout.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.XLEN(32), .ADDR_W(32)) a ();
    lsu_mem_port_if #(.XLEN(64), .ADDR_W(32)) b ();

    lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_a (
        .clk (clk), .rst (rst), .lsu (a.slave));
    lsu_mem_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(255)) u_b (
        .clk (clk), .rst (rst), .lsu (b.slave));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        a.req_valid = 1'b1; a.req_we = we; a.req_size = size;
        a.req_unsigned = uns; a.req_addr = addr; a.req_wdata = wdata;
    endtask

    task automatic req_b(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata);
        b.req_valid = 1'b1; b.req_we = we; b.req_size = size;
        b.req_unsigned = uns; b.req_addr = addr; b.req_wdata = wdata;
    endtask

    // Aligned access on the 32-bit port, acked in BUSY cycle dly (1 = first).
    task automatic acc_a(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int dly, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] rd);
        cyc(); req_a(we, size, uns, addr, wdata); #1;
        chk({tag, ".stall_idle"}, a.stall, 1);
        chk({tag, ".en_idle"}, a.mem_en, 0);
        for (int k = 1; k <= dly; k++) begin
            cyc();
            if (k == dly) begin a.mem_ack = 1'b1; a.mem_rdata = rdata; end
            #1;
            chk({tag, ".en"}, a.mem_en, 1);
            chk({tag, ".we"}, a.mem_we, we);
            chk({tag, ".be"}, a.mem_be, be);
            chk({tag, ".addr"}, a.mem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".wdata"}, a.mem_wdata, wd);
            chk({tag, ".stall_busy"}, a.stall, 1);
            chk({tag, ".rv_busy"}, a.rsp_valid, 0);
        end
        cyc(); a.mem_ack = 1'b0; a.mem_rdata = 32'hA5A5_A5A5; #1;
        chk({tag, ".rv"}, a.rsp_valid, 1);
        chk({tag, ".rdata"}, a.rsp_rdata, rd);
        chk({tag, ".stall_resp"}, a.stall, 0);
        chk({tag, ".en_resp"}, a.mem_en, 0);
        chk({tag, ".we_resp"}, a.mem_we, 0);
        chk({tag, ".flags"}, {a.misalign, a.timeout}, 0);
        cyc(); a.req_valid = 1'b0; #1;
        chk({tag, ".rv_after"}, a.rsp_valid, 0);
    endtask

    task automatic mis_a(input string tag, input logic [1:0] size, input logic [31:0] addr);
        cyc(); req_a(1'b0, size, 1'b0, addr, 32'h0); #1;
        chk({tag, ".stall"}, a.stall, 1);
        chk({tag, ".en0"}, a.mem_en, 0);
        cyc(); #1;
        chk({tag, ".rv"}, a.rsp_valid, 1);
        chk({tag, ".mis"}, a.misalign, 1);
        chk({tag, ".rdata"}, a.rsp_rdata, 0);
        chk({tag, ".en1"}, a.mem_en, 0);
        chk({tag, ".stall_resp"}, a.stall, 0);
        cyc(); a.req_valid = 1'b0; #1;
        chk({tag, ".mis_after"}, a.misalign, 0);
        chk({tag, ".rv_after"}, a.rsp_valid, 0);
    endtask

    // Word load at 0x4000 with no ack, or with an ack in the 8th BUSY cycle.
    task automatic to_a(input string tag, input logic ack8);
        cyc(); req_a(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0); #1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (ack8 && k == 8) begin a.mem_ack = 1'b1; a.mem_rdata = 32'h1234_5678; end
            #1;
            chk({tag, ".en"}, a.mem_en, 1);
            chk({tag, ".rv_busy"}, a.rsp_valid, 0);
        end
        cyc(); a.mem_ack = 1'b0; #1;
        chk({tag, ".en_drop"}, a.mem_en, 0);
        chk({tag, ".rv"}, a.rsp_valid, 1);
        chk({tag, ".to"}, a.timeout, ack8 ? 1'b0 : 1'b1);
        chk({tag, ".rdata"}, a.rsp_rdata, ack8 ? 32'h1234_5678 : 32'h0);
        cyc(); a.req_valid = 1'b0; #1;
        chk({tag, ".to_after"}, a.timeout, 0);
    endtask

    task automatic acc_b(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic mis, input logic [7:0] be, input logic [63:0] wd,
                         input logic [63:0] rd);
        cyc(); req_b(we, size, uns, addr, wdata); #1;
        if (mis) begin
            cyc(); #1;
            chk({tag, ".rv"}, b.rsp_valid, 1);
            chk({tag, ".mis"}, b.misalign, 1);
            chk({tag, ".en"}, b.mem_en, 0);
        end else begin
            cyc(); b.mem_ack = 1'b1; b.mem_rdata = rdata; #1;
            chk({tag, ".be"}, b.mem_be, be);
            chk({tag, ".wdata"}, b.mem_wdata, wd);
            chk({tag, ".addr"}, b.mem_addr, addr & 32'hFFFF_FFF8);
            cyc(); b.mem_ack = 1'b0; #1;
            chk({tag, ".rv"}, b.rsp_valid, 1);
            chk({tag, ".rdata"}, b.rsp_rdata, rd);
            chk({tag, ".mis"}, b.misalign, 0);
        end
        cyc(); b.req_valid = 1'b0; #1;
        chk({tag, ".rv_after"}, b.rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        a.req_valid = 0; a.req_we = 0; a.req_size = 0; a.req_unsigned = 0;
        a.req_addr = 0; a.req_wdata = 0; a.mem_rdata = 0; a.mem_ack = 0;
        b.req_valid = 0; b.req_we = 0; b.req_size = 0; b.req_unsigned = 0;
        b.req_addr = 0; b.req_wdata = 0; b.mem_rdata = 0; b.mem_ack = 0;
        repeat (3) cyc();
        #1;
        chk("rst.a_mem", {a.mem_en, a.mem_we, a.mem_be, a.stall}, 0);
        chk("rst.a_addr", a.mem_addr, 0);
        chk("rst.a_wdata", a.mem_wdata, 0);
        chk("rst.a_rsp", {a.rsp_valid, a.misalign, a.timeout}, 0);
        chk("rst.a_rdata", a.rsp_rdata, 0);
        chk("rst.b_mem", {b.mem_en, b.mem_be, b.rsp_valid}, 0);
        cyc(); rst = 1'b1;

        // Ack while idle must be ignored.
        cyc(); a.mem_ack = 1'b1; #1;
        chk("idle_ack.stall", a.stall, 0);
        cyc(); a.mem_ack = 1'b0; #1;
        chk("idle_ack.rv", a.rsp_valid, 0);
        chk("idle_ack.en", a.mem_en, 0);

        acc_a("lb",  1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF_1234, 1,
              4'b1000, 32'h0, 32'hFFFF_FF80);
        to_a("to_noack", 1'b0);
        to_a("to_ack8", 1'b1);
        mis_a("mis_lw", 2'b10, 32'h3001);
        mis_a("mis_lh", 2'b01, 32'h3003);
        mis_a("mis_ld32", 2'b11, 32'h3000);
        acc_a("sh",  1'b1, 2'b01, 1'b0, 32'h2002, 32'hDEAD_BEEF, 32'h0, 4,
              4'b1100, 32'hBEEF_BEEF, 32'h0);
        acc_a("sb",  1'b1, 2'b00, 1'b0, 32'h1001, 32'h1234_56AB, 32'h0, 1,
              4'b0010, 32'hABAB_ABAB, 32'h0);
        acc_a("lwu_full", 1'b0, 2'b10, 1'b1, 32'h8000, 32'h0, 32'h8000_0001, 2,
              4'b1111, 32'h0, 32'h8000_0001);
        acc_a("lh",  1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h7FFF_8000, 1,
              4'b1100, 32'h0, 32'h0000_7FFF);

        // Reset in the second BUSY cycle of a store, then a late ack.
        cyc(); req_a(1'b1, 2'b10, 1'b0, 32'h7000, 32'hCAFE_F00D); #1;
        cyc(); #1;
        chk("rstbusy.en", a.mem_en, 1);
        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1; a.req_valid = 1'b0; a.mem_ack = 1'b1; #1;
        chk("rstbusy.mem", {a.mem_en, a.mem_we, a.mem_be, a.stall}, 0);
        chk("rstbusy.addr", a.mem_addr, 0);
        chk("rstbusy.wdata", a.mem_wdata, 0);
        chk("rstbusy.rsp", {a.rsp_valid, a.misalign, a.timeout}, 0);
        chk("rstbusy.rdata", a.rsp_rdata, 0);
        cyc(); a.mem_ack = 1'b0; #1;
        chk("rstbusy.late_rv", a.rsp_valid, 0);
        chk("rstbusy.late_en", a.mem_en, 0);
        acc_a("lbu_post", 1'b0, 2'b00, 1'b1, 32'h5001, 32'h0, 32'h0000_9A00, 1,
              4'b0010, 32'h0, 32'h0000_009A);

        acc_b("lhu64", 1'b0, 2'b01, 1'b1, 32'h6006, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0,
              8'hC0, 64'h0, 64'h0000_0000_0000_BEEF);
        acc_b("lw64",  1'b0, 2'b10, 1'b0, 32'h6004, 64'h0, 64'h8765_4321_0000_0000, 1'b0,
              8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
        acc_b("lwu64", 1'b0, 2'b10, 1'b1, 32'h6004, 64'h0, 64'h8765_4321_0000_0000, 1'b0,
              8'hF0, 64'h0, 64'h0000_0000_8765_4321);
        acc_b("sd64",  1'b1, 2'b11, 1'b0, 32'h6008, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0,
              8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
        acc_b("sb64",  1'b1, 2'b00, 1'b0, 32'h600D, 64'h0000_0000_0000_005A, 64'h0, 1'b0,
              8'h20, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0);
        acc_b("ldu64", 1'b0, 2'b11, 1'b1, 32'h6000, 64'h0, 64'h8000_0000_0000_0001, 1'b0,
              8'hFF, 64'h0, 64'h8000_0000_0000_0001);
        acc_b("mis_ld64", 1'b0, 2'b11, 1'b0, 32'h600C, 64'h0, 64'h0, 1'b1,
              8'h00, 64'h0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
